// File: rtl/pixel_write_sink_if.sv
// Pixel-stream and framebuffer-write signals of pixel_write_sink.
// The master side is the drawing datapath plus the framebuffer; the slave side is the sink.
interface pixel_write_sink_if;
    logic [8:0]  X_in;
    logic [7:0]  Y_in;
    logic [2:0]  colour_in;
    logic        write_en;
    logic        sink_ready;
    logic [16:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_wren;
    logic        mem_ack;

    modport master (
        output X_in, Y_in, colour_in, write_en, mem_ack,
        input  sink_ready, mem_addr, mem_data, mem_wren
    );

    modport slave (
        input  X_in, Y_in, colour_in, write_en, mem_ack,
        output sink_ready, mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/pixel_write_sink.sv
// Clips incoming pixels, converts them to framebuffer addresses and queues them for the memory port.
// Define PIXEL_SINK_TRANSPARENT_EN to drop in-range pixels of colour 3'b101.
module pixel_write_sink #(
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    pixel_write_sink_if.slave     bus,
    output logic [15:0]           clipped_count,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_L  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [9:0]     W_L     = 10'(SCREEN_W);
    localparam logic [8:0]     H_L     = 9'(SCREEN_H);

    typedef struct packed {
        logic [16:0] addr;
        logic [2:0]  colour;
    } entry_t;

    entry_t             fifo_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W:0]     count_r;
    logic [16:0]        mem_addr_r;
    logic [2:0]         mem_data_r;
    logic               mem_wren_r;
    logic [15:0]        clipped_r;
    logic               overflow_r;

    logic [16:0]        addr_s;
    logic               in_range_s;
    logic               transparent_s;
    logic               accept_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic               clip_s;
    logic [PTR_W:0]     remaining_s;
    logic [PTR_W:0]     count_next_s;
    logic [PTR_W-1:0]   rd_ptr_next_s;
    entry_t             head_next_s;

    // Pixel classification, FIFO control and next head-of-queue selection.
    always_comb begin
        addr_s        = 17'(bus.Y_in) * 17'(SCREEN_W) + 17'(bus.X_in);
        in_range_s    = ({1'b0, bus.X_in} < W_L) && ({1'b0, bus.Y_in} < H_L);
`ifdef PIXEL_SINK_TRANSPARENT_EN
        transparent_s = (bus.colour_in == 3'b101);
`else
        transparent_s = 1'b0;
`endif
        full_s        = (count_r == FULL_L);
        pop_s         = mem_wren_r && bus.mem_ack;
        accept_s      = bus.write_en && in_range_s && !transparent_s;
        push_s        = accept_s && (!full_s || pop_s);
        drop_s        = accept_s && full_s && !pop_s;
        clip_s        = bus.write_en && !in_range_s;
        remaining_s   = count_r - {{PTR_W{1'b0}}, pop_s};
        count_next_s  = remaining_s + {{PTR_W{1'b0}}, push_s};
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        // A pixel entering an otherwise-empty queue bypasses storage so it shows next cycle.
        if (count_next_s == {(PTR_W + 1){1'b0}}) begin
            head_next_s = {17'd0, 3'd0};
        end else if (remaining_s == {(PTR_W + 1){1'b0}}) begin
            head_next_s = {addr_s, bus.colour_in};
        end else begin
            head_next_s = fifo_r[rd_ptr_next_s];
        end
    end

    // Pixel storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clock) begin
        if (push_s && !reset) begin
            fifo_r[wr_ptr_r] <= {addr_s, bus.colour_in};
        end
    end

    // Pointers, occupancy, registered memory port and status counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W + 1){1'b0}};
            mem_addr_r <= 17'd0;
            mem_data_r <= 3'd0;
            mem_wren_r <= 1'b0;
            clipped_r  <= 16'd0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= count_next_s;
            mem_addr_r <= head_next_s.addr;
            mem_data_r <= head_next_s.colour;
            mem_wren_r <= (count_next_s != {(PTR_W + 1){1'b0}});
            if (clip_s && (clipped_r != 16'hFFFF)) begin
                clipped_r <= clipped_r + 16'd1;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign bus.sink_ready = (count_r != FULL_L);
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_data   = mem_data_r;
    assign bus.mem_wren   = mem_wren_r;
    assign clipped_count  = clipped_r;
    assign overflow       = overflow_r;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed scenarios plus randomized traffic for pixel_write_sink, checked against a queue model.
module tb_pixel_write_sink;

    localparam int W = 320;
    localparam int H = 240;
    localparam int D = 4;

    logic        clock;
    logic        reset;
    logic [15:0] clipped_count;
    logic        overflow;
    int          checks;
    int          errors;

    // Reference model: queue of {address, colour} plus status.
    logic [19:0] q_m [$];
    int          clip_m;
    bit          ovf_m;

    pixel_write_sink_if bus_if ();

    pixel_write_sink #(.SCREEN_W(W), .SCREEN_H(H), .FIFO_DEPTH(D)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus_if),
        .clipped_count (clipped_count),
        .overflow      (overflow)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit we, input int x, input int y, input int c, input bit ack);
        bus_if.write_en  = we;
        bus_if.X_in      = 9'(x);
        bus_if.Y_in      = 8'(y);
        bus_if.colour_in = 3'(c);
        bus_if.mem_ack   = ack;
    endtask

    task automatic model_edge();
        int  x;
        int  y;
        int  c;
        bit  in_r;
        bit  transp;
        bit  popping;
        x       = int'(bus_if.X_in);
        y       = int'(bus_if.Y_in);
        c       = int'(bus_if.colour_in);
        in_r    = (x < W) && (y < H);
        transp  = 1'b0;
`ifdef PIXEL_SINK_TRANSPARENT_EN
        transp  = (c == 5);
`endif
        popping = (q_m.size() > 0) && bus_if.mem_ack;
        if (bus_if.write_en && !in_r && clip_m < 65535) clip_m++;
        if (bus_if.write_en && in_r && !transp) begin
            if (q_m.size() < D || popping) begin
                if (popping) void'(q_m.pop_front());
                q_m.push_back({17'(y * W + x), 3'(c)});
                popping = 1'b0;
            end else begin
                ovf_m = 1'b1;
            end
        end
        if (popping) void'(q_m.pop_front());
    endtask

    task automatic compare_all(input string tag);
        logic [19:0] head;
        check_eq({tag, "_wren"}, 32'(bus_if.mem_wren), 32'(q_m.size() != 0));
        if (q_m.size() != 0) begin
            head = q_m[0];
            check_eq({tag, "_addr"}, 32'(bus_if.mem_addr), 32'(head[19:3]));
            check_eq({tag, "_data"}, 32'(bus_if.mem_data), 32'(head[2:0]));
        end
        check_eq({tag, "_ready"}, 32'(bus_if.sink_ready), 32'(q_m.size() != D));
        check_eq({tag, "_clip"}, 32'(clipped_count), 32'(clip_m));
        check_eq({tag, "_ovf"}, 32'(overflow), 32'(ovf_m));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check_eq("rst_wren", 32'(bus_if.mem_wren), 32'd0);
        check_eq("rst_addr", 32'(bus_if.mem_addr), 32'd0);
        check_eq("rst_data", 32'(bus_if.mem_data), 32'd0);
        check_eq("rst_ready", 32'(bus_if.sink_ready), 32'd1);
        check_eq("rst_clip", 32'(clipped_count), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        q_m.delete();
        clip_m = 0;
        ovf_m  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0);
        #2;
        apply_reset();

        // Scenario 1: single pixel, one-cycle latency, then idle.
        drive(1'b1, 5, 2, 6, 1'b1);
        step("s1a");
        check_eq("s1_addr", 32'(bus_if.mem_addr), 32'd645);
        drive(1'b0, 0, 0, 0, 1'b1);
        step("s1b");
        check_eq("s1_idle", 32'(bus_if.mem_wren), 32'd0);

        // Scenario 2: two clipped pixels and the far corner.
        drive(1'b1, 320, 0, 1, 1'b1);   step("s2a");
        drive(1'b1, 0, 240, 2, 1'b1);   step("s2b");
        drive(1'b1, 319, 239, 3, 1'b1); step("s2c");
        check_eq("s2_corner", 32'(bus_if.mem_addr), 32'd76799);
        check_eq("s2_clip", 32'(clipped_count), 32'd2);
        drive(1'b0, 0, 0, 0, 1'b1);     step("s2d");

        // Scenario 3: fill without acks, lose the fifth, then drain in order.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i, 0, i, 1'b0);
            step("s3fill");
        end
        check_eq("s3_ovf", 32'(overflow), 32'd1);
        check_eq("s3_ready", 32'(bus_if.sink_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 0, 0, 0, 1'b1);
            step("s3drain");
        end
        apply_reset();

        // Scenario 4: write into a full FIFO on a popping edge.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i + 20, 1, 2, 1'b0);
            step("s4fill");
        end
        drive(1'b1, 100, 3, 4, 1'b1); step("s4both");
        check_eq("s4_ovf", 32'(overflow), 32'd0);
        drive(1'b0, 0, 0, 0, 1'b0);   step("s4hold");
        check_eq("s4_full", 32'(bus_if.sink_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 0, 0, 0, 1'b1);
            step("s4drain");
        end

        // Scenario 5: colour 3'b101.
        drive(1'b1, 10, 10, 5, 1'b1); step("s5");
`ifdef PIXEL_SINK_TRANSPARENT_EN
        check_eq("s5_wren", 32'(bus_if.mem_wren), 32'd0);
`else
        check_eq("s5_addr", 32'(bus_if.mem_addr), 32'd3210);
`endif
        drive(1'b0, 0, 0, 0, 1'b1);   step("s5b");

        // Scenario 6: reset mid-operation with pending pixels.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i, 7, 1, 1'b0);
            step("s6fill");
        end
        drive(1'b0, 0, 0, 0, 1'b1);
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step("s6after");
        end

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(3, 0) != 0, int'($urandom_range(330, 0)), int'($urandom_range(250, 0)),
                  int'($urandom_range(7, 0)), $urandom_range(2, 0) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_write_sink.md
PIXEL_WRITE_SINK -- requirements
Module: pixel_write_sink

Interface
REQ-001 The parameter SCREEN_W SHALL default to 320 and sets the visible width in pixels.
REQ-002 The parameter SCREEN_H SHALL default to 240 and sets the visible height in pixels.
REQ-003 The parameter FIFO_DEPTH SHALL default to 4 and sets the pending-pixel buffer depth, restricted to a power of two, 2 to 16.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 X_in  in  9  pixel column from the drawing datapath.
REQ-008 Y_in  in  8  pixel row from the drawing datapath.
REQ-009 colour_in  in  3  pixel colour.
REQ-010 write_en  in  1  pixel-valid strobe, one pixel per cycle.
REQ-011 sink_ready  out  1  high when the FIFO is not full.
REQ-012 mem_addr  out  17  framebuffer word address of the FIFO head.
REQ-013 mem_data  out  3  colour of the FIFO head.
REQ-014 mem_wren  out  1  high when the FIFO is non-empty.
REQ-015 mem_ack  in  1  framebuffer accepted the head this cycle.
REQ-016 clipped_count  out  16  count of out-of-range pixels, saturating.
REQ-017 overflow  out  1  sticky flag: a pixel was lost because the FIFO was full.

Function
REQ-018 The address SHALL be Y_in*SCREEN_W + X_in, computed at 17 bits with no truncation; the maximum is 76799.
REQ-019 A pixel SHALL be in range iff X_in < SCREEN_W and Y_in < SCREEN_H.
REQ-020 On a clock edge with write_en=1, an in-range pixel and the FIFO not full, the block SHALL push {address, colour_in}.
REQ-021 If the FIFO is full and a pop occurs on the same edge, the in-range pixel SHALL still be pushed; occupancy is unchanged and overflow is not set.
REQ-022 If the FIFO is full with no pop on that edge, the in-range pixel SHALL be discarded and overflow SHALL be set to 1 and held until reset.
REQ-023 An out-of-range pixel with write_en=1 SHALL never be pushed, and clipped_count SHALL increment, saturating at 16'hFFFF.
REQ-024 Occupancy, clipping and overflow SHALL be ignored when write_en=0.
REQ-025 A pop SHALL occur on any edge with mem_wren=1 and mem_ack=1.
REQ-026 mem_ack while the FIFO is empty SHALL have no effect.
REQ-027 Pixels SHALL leave the FIFO in strict arrival order.
REQ-028 With an empty FIFO, a pixel pushed on edge N SHALL appear on mem_addr/mem_data with mem_wren=1 in the cycle after edge N (1-cycle latency).
REQ-029 mem_addr and mem_data SHALL be stable while mem_wren=1 and mem_ack=0.
REQ-030 sink_ready SHALL be combinational from occupancy only: 0 when occupancy equals FIFO_DEPTH, otherwise 1.
REQ-031 The read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 The occupancy counter SHALL span 0..FIFO_DEPTH inclusive.

Reset
REQ-033 On reset assertion, the block SHALL immediately, without a clock, empty the FIFO and set mem_wren=0, mem_addr=0, mem_data=0, clipped_count=0, overflow=0 and sink_ready=1.
REQ-034 Pending pixels SHALL be discarded on reset mid-operation.
REQ-035 No push or pop SHALL occur on any edge while reset=1.

Configuration
REQ-036 The preprocessor macro PIXEL_SINK_TRANSPARENT_EN SHALL control transparency handling.
REQ-037 With PIXEL_SINK_TRANSPARENT_EN defined, an in-range pixel with colour_in=3'b101 SHALL be discarded: not pushed, and neither clipped_count nor overflow is affected.
REQ-038 With PIXEL_SINK_TRANSPARENT_EN defined, clipping SHALL take precedence over transparency, so an out-of-range transparent pixel increments clipped_count.
REQ-039 Without PIXEL_SINK_TRANSPARENT_EN, colour 3'b101 SHALL be treated as an ordinary colour.

Verification
REQ-040 Scenario 1: after reset, write X=5, Y=2, colour=110 with mem_ack=1 -> next cycle mem_wren=1, mem_addr=645, mem_data=110; the cycle after, mem_wren=0.
REQ-041 Scenario 2: write X=320,Y=0, then X=0,Y=240, then X=319,Y=239 -> clipped_count=2 and a single memory write to address 76799.
REQ-042 Scenario 3: mem_ack=0, five in-range writes to addresses 0..4 -> sink_ready=0 after the 4th, overflow=1, address 4 absent; then mem_ack=1 -> addresses 0,1,2,3 on four consecutive cycles.
REQ-043 Scenario 4: FIFO full, write and mem_ack=1 on the same edge -> pixel accepted, occupancy stays 4, overflow stays 0.
REQ-044 Scenario 5: write X=10, Y=10, colour=101 -> macro defined: no mem_wren and counters unchanged; macro undefined: write to address 3210.
REQ-045 Scenario 6: three pixels pending with mem_ack=0, assert reset between edges -> mem_wren=0 and sink_ready=1 before the next edge; after release, no stale pixel is emitted.
